cache_color_ctrl: RTL



---
 rtl/cache_color_pkg.sv | 26 ++
 rtl/cache_color_addr_gen.sv | 25 ++
 rtl/cache_color_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/cache_color_pkg.sv
// Shared types and constants for the colour-cache sequencer.
package cache_color_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_SETTLE0,
      ST_PRES0,
      ST_SHIFT,
      ST_SETTLE1,
      ST_PRES1,
      ST_FIN
   } ctrl_state_t;

   localparam int CACHE_WORDS   = 6;
   localparam int CHANNELS      = 3;
   localparam int WORDS_PER_CH  = 2;
   localparam int WIN_PER_CHUNK = 2;
   localparam int CACHE_DI_W    = 33;
   localparam int DATA_W        = 16;
   localparam int WORD_IDX_W    = 3;

   localparam logic [WORD_IDX_W-1:0] LAST_WORD = WORD_IDX_W'(CACHE_WORDS - 1);

endpackage

// File: rtl/cache_color_addr_gen.sv
// Maps (base, cache word index, chunk index) to a pixel-memory word address.
module cache_color_addr_gen
   import cache_color_pkg::*;
#(
   parameter int          ADDR_W       = 16,
   parameter int unsigned PLANE_STRIDE = 'h4000,
   parameter int          CNT_W        = 12
) (
   input  logic [ADDR_W-1:0]     base_i,
   input  logic [WORD_IDX_W-1:0] word_i,
   input  logic [CNT_W-1:0]      chunk_i,
   output logic [ADDR_W-1:0]     addr_o
);

   logic [ADDR_W-1:0] planeOff;
   logic [ADDR_W-1:0] chunkOff;

   // Word pairs belong to one colour plane; the low half selects the word within the chunk.
   // All sums are truncated to ADDR_W so addresses wrap around the memory.
   assign planeOff = ADDR_W'(32'(word_i) / 32'(WORDS_PER_CH)) * ADDR_W'(PLANE_STRIDE);
   assign chunkOff = ADDR_W'(chunk_i) * ADDR_W'(WORDS_PER_CH)
                   + ADDR_W'(32'(word_i) % 32'(WORDS_PER_CH));
   assign addr_o   = base_i + planeOff + chunkOff;

endmodule

// File: rtl/cache_color_ctrl.sv
// Sequencer that fills the 3-channel colour cache chunk by chunk and presents
// two shifted 24-bit windows per chunk to a valid/ready consumer.
module cache_color_ctrl
   import cache_color_pkg::*;
#(
   parameter int          ADDR_W       = 16,
   parameter int unsigned PLANE_STRIDE = 'h4000,
   parameter int          CNT_W        = 12
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_i,
   input  logic [ADDR_W-1:0]     base_addr_i,
   input  logic [CNT_W-1:0]      num_chunks_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  mem_rd_o,
   output logic [ADDR_W-1:0]     mem_addr_o,
   input  logic                  mem_rvalid_i,
   input  logic [DATA_W-1:0]     mem_rdata_i,
   output logic                  cache_we_o,
   output logic                  cache_sh_o,
   output logic [WORD_IDX_W-1:0] cache_addr_o,
   output logic [CACHE_DI_W-1:0] cache_di_o,
   output logic                  win_valid_o,
   input  logic                  win_ready_i
);

   ctrl_state_t           state_q, state_d;
   logic [WORD_IDX_W-1:0] word_q, word_d;
   logic [CNT_W-1:0]      chunk_q, chunk_d;
   logic [ADDR_W-1:0]     base_q, base_d;
   logic [CNT_W-1:0]      num_q, num_d;
   logic                  busy_q, done_q, memRd_q, cacheSh_q, winValid_q;
   logic [ADDR_W-1:0]     memAddr_q;
   logic [ADDR_W-1:0]     genAddr;
   logic                  wrAccept;

   // Address is computed for the word about to be requested so it can be registered with mem_rd.
   cache_color_addr_gen #(
      .ADDR_W      (ADDR_W),
      .PLANE_STRIDE(PLANE_STRIDE),
      .CNT_W       (CNT_W)
   ) u_addr_gen (
      .base_i (base_d),
      .word_i (word_d),
      .chunk_i(chunk_d),
      .addr_o (genAddr)
   );

   // Read data goes straight into the cache in the cycle it arrives.
   assign wrAccept     = (state_q == ST_WAIT) && mem_rvalid_i;
   assign cache_we_o   = wrAccept;
   assign cache_addr_o = wrAccept ? word_q : '0;
   assign cache_di_o   = wrAccept ? CACHE_DI_W'(mem_rdata_i) : '0;

   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      chunk_d = chunk_q;
      base_d  = base_q;
      num_d   = num_q;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               base_d  = base_addr_i;
               num_d   = num_chunks_i;
               word_d  = '0;
               chunk_d = '0;
               state_d = (num_chunks_i == '0) ? ST_FIN : ST_REQ;
            end
         end
         ST_REQ: state_d = ST_WAIT;
         ST_WAIT: begin
            if (mem_rvalid_i) begin
               if (word_q == LAST_WORD) begin
                  state_d = ST_SETTLE0;
               end else begin
                  word_d  = word_q + WORD_IDX_W'(1);
                  state_d = ST_REQ;
               end
            end
         end
         ST_SETTLE0: state_d = ST_PRES0;
         ST_PRES0: begin
            if (win_ready_i) state_d = ST_SHIFT;
         end
         ST_SHIFT:   state_d = ST_SETTLE1;
         ST_SETTLE1: state_d = ST_PRES1;
         ST_PRES1: begin
            if (win_ready_i) begin
               chunk_d = chunk_q + CNT_W'(1);
               if (chunk_d == num_q) begin
                  state_d = ST_FIN;
               end else begin
                  word_d  = '0;
                  state_d = ST_REQ;
               end
            end
         end
         ST_FIN:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they appear registered, aligned with the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         word_q     <= '0;
         chunk_q    <= '0;
         base_q     <= '0;
         num_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         memRd_q    <= 1'b0;
         memAddr_q  <= '0;
         cacheSh_q  <= 1'b0;
         winValid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         word_q     <= word_d;
         chunk_q    <= chunk_d;
         base_q     <= base_d;
         num_q      <= num_d;
         busy_q     <= (state_d != ST_IDLE);
         done_q     <= (state_d == ST_FIN);
         memRd_q    <= (state_d == ST_REQ);
         cacheSh_q  <= (state_d == ST_SHIFT);
         winValid_q <= (state_d == ST_PRES0) || (state_d == ST_PRES1);
         if (state_d == ST_REQ) memAddr_q <= genAddr;
      end
   end

   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign mem_rd_o    = memRd_q;
   assign mem_addr_o  = memAddr_q;
   assign cache_sh_o  = cacheSh_q;
   assign win_valid_o = winValid_q;

endmodule
